// File: rtl/skid_buffer_pkg.sv
// skid_buffer_pkg: occupancy state encoding shared by the skid buffer.
package skid_buffer_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_e;
endpackage

// File: rtl/skid_buffer_if.sv
// skid_buffer_if: valid/ready hand-off bundle seen from the buffer (slave) and its neighbours (master).
interface skid_buffer_if #(parameter int width = 32);
    logic             v_i;
    logic             ready_o;
    logic [width-1:0] data_i;
    logic             v_o;
    logic             ready_i;
    logic [width-1:0] data_o;
    modport slave (input v_i, data_i, ready_i, output ready_o, v_o, data_o);
    modport master (output v_i, data_i, ready_i, input ready_o, v_o, data_o);
endinterface

// File: rtl/skid_buffer_dff.sv
// skid_buffer_dff: enable-gated register cleared to zero by synchronous reset.
module skid_buffer_dff #(parameter int width = 32) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [width-1:0] d_i,
    output logic [width-1:0] q_o
);
    always_ff @(posedge clk_i)
        q_o <= rst_i ? '0 : en_i ? d_i : q_o;
endmodule

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready skid buffer; ready_o depends on state only.
module skid_buffer
    import skid_buffer_pkg::*;
#(parameter int width = 32) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    skid_buffer_if.slave  bus
);
    skid_state_e      r_state, w_state_next;
    logic             w_in, w_out, w_main_en, w_skid_en;
    logic [width-1:0] w_main_d, r_main, r_skid;

    assign bus.v_o     = r_state != EMPTY;
    assign bus.ready_o = r_state != FULL;
    assign bus.data_o  = r_main;
    assign w_in        = bus.v_i & bus.ready_o;
    assign w_out       = bus.v_o & bus.ready_i;

    always_comb begin
        w_state_next = r_state;
        w_main_en    = 1'b0;
        w_skid_en    = 1'b0;
        w_main_d     = bus.data_i;
        case (r_state)
            EMPTY: begin
                w_main_en    = w_in;
                w_state_next = w_in ? ONE : EMPTY;
            end
            ONE: begin
                w_main_en    = w_in & w_out;
                w_skid_en    = w_in & ~w_out;
                w_state_next = (w_in & ~w_out) ? FULL : (~w_in & w_out) ? EMPTY : ONE;
            end
            FULL: begin
                w_main_en    = w_out;
                w_main_d     = r_skid;
                w_state_next = w_out ? ONE : FULL;
            end
            default: w_state_next = EMPTY;
        endcase
        // flush drops any incoming entry and leaves the payload registers untouched
        if (flush_i) begin
            w_state_next = EMPTY;
            w_main_en    = 1'b0;
            w_skid_en    = 1'b0;
        end
    end

    always_ff @(posedge clk_i)
        r_state <= rst_i ? EMPTY : w_state_next;

    skid_buffer_dff #(.width(width)) u_main (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(w_main_en), .d_i(w_main_d), .q_o(r_main)
    );

    skid_buffer_dff #(.width(width)) u_skid (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(w_skid_en), .d_i(bus.data_i), .q_o(r_skid)
    );
endmodule
